// File: rtl/paddle_input_ctl_if.sv
// paddle_input_ctl_if: mouse/blanking inputs and paddle/pulse outputs of paddle_input_ctl.
// master drives the mouse and blanking inputs; slave is the conditioning block.
interface paddle_input_ctl_if;
    logic        vblnk_in;
    logic [11:0] ypos_in;
    logic [11:0] ypos_sec_in;
    logic        mouse_left_in;
    logic [11:0] paddle_y;
    logic [11:0] paddle_y_sec;
    logic        frame_tick;
    logic        start_pulse;
    modport master (
        output vblnk_in, ypos_in, ypos_sec_in, mouse_left_in,
        input  paddle_y, paddle_y_sec, frame_tick, start_pulse
    );
    modport slave (
        input  vblnk_in, ypos_in, ypos_sec_in, mouse_left_in,
        output paddle_y, paddle_y_sec, frame_tick, start_pulse
    );
endinterface

// File: rtl/paddle_input_ctl.sv
// paddle_input_ctl: per-frame paddle sampling with clamp, plus debounced start button.
// Define PADDLE_SLEW_EN to limit paddle motion to MAX_STEP lines per frame.
module paddle_input_ctl #(
    parameter int SCREEN_H        = 768,
    parameter int PADDLE_H        = 100,
    parameter int MAX_STEP        = 16,
    parameter int DEBOUNCE_CYCLES = 65000
) (
    input logic              clk,
    input logic              rst,
    paddle_input_ctl_if.slave bus
);
    localparam int YMAX = SCREEN_H - PADDLE_H;
    localparam logic [11:0] YMAX_W = 12'(YMAX);
    localparam logic [11:0] YMID_W = 12'(YMAX / 2);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    if (MAX_STEP < 1 || PADDLE_H >= SCREEN_H || DEBOUNCE_CYCLES < 2) begin : g_bad_params
        $error("paddle_input_ctl: invalid parameters");
    end

    typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

    logic [11:0] y_q, y_d, ys_q, ys_d;
    logic        vprev_q, tick_q, rise;
    state_t      state_q;
    logic [CW-1:0] cnt_q;
    logic        start_q;

    function automatic logic [11:0] clamp(input logic [11:0] v);
        return v > YMAX_W ? YMAX_W : v;
    endfunction

`ifdef PADDLE_SLEW_EN
    localparam logic [11:0] STEP_W = 12'(MAX_STEP);

    // Differences are only consumed on the side where they cannot underflow.
    function automatic logic [11:0] slew(input logic [11:0] cur, input logic [11:0] tgt);
        logic [11:0] up, dn;
        up = tgt - cur;
        dn = cur - tgt;
        return tgt > cur ? cur + (up > STEP_W ? STEP_W : up) :
               tgt < cur ? cur - (dn > STEP_W ? STEP_W : dn) : cur;
    endfunction
`endif

    always_comb begin
        rise = bus.vblnk_in & ~vprev_q;
`ifdef PADDLE_SLEW_EN
        y_d  = rise ? slew(y_q, clamp(bus.ypos_in)) : y_q;
        ys_d = rise ? slew(ys_q, clamp(bus.ypos_sec_in)) : ys_q;
`else
        y_d  = rise ? clamp(bus.ypos_in) : y_q;
        ys_d = rise ? clamp(bus.ypos_sec_in) : ys_q;
`endif
    end

    // vprev resets high so blanking already active at release is not a frame edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            vprev_q <= 1'b1;
            tick_q  <= 1'b0;
            y_q     <= YMID_W;
            ys_q    <= YMID_W;
        end else begin
            vprev_q <= bus.vblnk_in;
            tick_q  <= rise;
            y_q     <= y_d;
            ys_q    <= ys_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            start_q <= 1'b0;
        end else begin
            start_q <= 1'b0;
            case (state_q)
                IDLE: if (bus.mouse_left_in) begin
                    state_q <= PRESS_WAIT;
                    cnt_q   <= CW'(1);
                end
                PRESS_WAIT: if (!bus.mouse_left_in) begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_q <= HELD;
                    cnt_q   <= '0;
                    start_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
                HELD: if (!bus.mouse_left_in) begin
                    state_q <= RELEASE_WAIT;
                    cnt_q   <= CW'(1);
                end
                RELEASE_WAIT: if (bus.mouse_left_in) begin
                    state_q <= HELD;
                    cnt_q   <= '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign bus.paddle_y     = y_q;
    assign bus.paddle_y_sec = ys_q;
    assign bus.frame_tick   = tick_q;
    assign bus.start_pulse  = start_q;
endmodule

// File: tb/tb_paddle_input_ctl.sv
// tb_paddle_input_ctl: scoreboard bench; a run-length/arithmetic model queues expected ticks and pulses.
module tb_paddle_input_ctl;
    localparam int YMAX = 668;
    localparam int YMID = 334;
    localparam int D    = 16;
`ifdef PADDLE_SLEW_EN
    localparam int STEP = 16;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    paddle_input_ctl_if bus();

    paddle_input_ctl #(.DEBOUNCE_CYCLES(D)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct packed { int stamp; int y; int ys; } fr_t;
    fr_t fq[$];
    int  pq[$];
    int  checks = 0;
    int  fails  = 0;
    int  cyc    = 0;
    bit  m_prev, m_pressed;
    int  m_y, m_ys, m_run;

    function automatic int next_pos(input int cur, input int v);
        int t;
        t = v > YMAX ? YMAX : v;
`ifdef PADDLE_SLEW_EN
        return cur + ((t - cur) > STEP ? STEP : (t - cur) < -STEP ? -STEP : (t - cur));
`else
        return t + 0 * cur;
`endif
    endfunction

    // Reference: frame update on blanking rise; button flips after D consecutive differing samples.
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_prev = 1'b1; m_y = YMID; m_ys = YMID; m_pressed = 1'b0; m_run = 0;
        end else begin
            if (bus.vblnk_in && !m_prev) begin
                m_y  = next_pos(m_y, int'(bus.ypos_in));
                m_ys = next_pos(m_ys, int'(bus.ypos_sec_in));
                fq.push_back('{cyc, m_y, m_ys});
            end
            m_prev = bus.vblnk_in;
            if (bus.mouse_left_in != m_pressed) begin
                m_run++;
                if (m_run == D) begin
                    m_pressed = ~m_pressed;
                    m_run = 0;
                    if (m_pressed) pq.push_back(cyc);
                end
            end else m_run = 0;
        end
    end

    always @(negedge clk) begin
        fr_t e;
        while (fq.size() > 0 && fq[0].stamp < cyc) begin
            checks++; fails++;
            $display("FAIL frame_tick_missing: tick expected at cycle %0d but not observed", fq[0].stamp);
            void'(fq.pop_front());
        end
        while (pq.size() > 0 && pq[0] < cyc) begin
            checks++; fails++;
            $display("FAIL start_pulse_missing: pulse expected at cycle %0d but not observed", pq[0]);
            void'(pq.pop_front());
        end
        if (bus.frame_tick) begin
            checks++;
            if (fq.size() == 0 || fq[0].stamp != cyc) begin
                fails++;
                $display("FAIL frame_tick_spurious: tick=1 at cycle %0d, required 0", cyc);
            end else begin
                e = fq.pop_front();
                checks++;
                if (int'(bus.paddle_y) != e.y || int'(bus.paddle_y_sec) != e.ys) begin
                    fails++;
                    $display("FAIL frame_update: cycle %0d got %0d/%0d, required %0d/%0d",
                             cyc, bus.paddle_y, bus.paddle_y_sec, e.y, e.ys);
                end
            end
        end
        if (bus.start_pulse) begin
            checks++;
            if (pq.size() == 0 || pq[0] != cyc) begin
                fails++;
                $display("FAIL start_pulse_spurious: pulse=1 at cycle %0d, required 0", cyc);
            end else void'(pq.pop_front());
        end
        checks++;
        if (int'(bus.paddle_y) != m_y || int'(bus.paddle_y_sec) != m_ys) begin
            fails++;
            $display("FAIL paddle_hold: cycle %0d got %0d/%0d, required %0d/%0d",
                     cyc, bus.paddle_y, bus.paddle_y_sec, m_y, m_ys);
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic frame(input int lo, input int hi);
        bus.vblnk_in = 1'b0; wait_cyc(lo);
        bus.vblnk_in = 1'b1; wait_cyc(hi);
    endtask

    task automatic expect_val(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    initial begin
        int vcnt, bcnt;
        bus.vblnk_in = 1'b0; bus.ypos_in = 12'd500; bus.ypos_sec_in = 12'd500; bus.mouse_left_in = 1'b0;
        wait_cyc(3);
        expect_val("reset_paddle_y", int'(bus.paddle_y), YMID);
        expect_val("reset_paddle_y_sec", int'(bus.paddle_y_sec), YMID);
        expect_val("reset_frame_tick", int'(bus.frame_tick), 0);
        expect_val("reset_start_pulse", int'(bus.start_pulse), 0);
        rst = 1'b0;
        wait_cyc(20);
        expect_val("no_frame_no_change", int'(bus.paddle_y), YMID);
        bus.ypos_in = 12'd400; bus.ypos_sec_in = 12'd1000;
        repeat (5) frame(3, 4);
        expect_val("five_frames_y", int'(bus.paddle_y), 400);
`ifdef PADDLE_SLEW_EN
        expect_val("five_frames_sec", int'(bus.paddle_y_sec), YMID + 5 * 16);
`else
        expect_val("clamp_sec", int'(bus.paddle_y_sec), YMAX);
`endif
        bus.vblnk_in = 1'b0; bus.ypos_in = 12'd200; wait_cyc(2);
        bus.vblnk_in = 1'b1;
        for (int i = 0; i < 50; i++) begin
            wait_cyc(1);
            bus.ypos_in = 12'(200 + i * 8);
        end
        bus.vblnk_in = 1'b0; wait_cyc(2);
        bus.mouse_left_in = 1'b1; wait_cyc(10);
        bus.mouse_left_in = 1'b0; wait_cyc(30);
        bus.mouse_left_in = 1'b1; wait_cyc(1000);
        bus.mouse_left_in = 1'b0; wait_cyc(8);
        bus.mouse_left_in = 1'b1; wait_cyc(5);
        bus.mouse_left_in = 1'b0; wait_cyc(20);
        bus.mouse_left_in = 1'b1; wait_cyc(30);
        bus.mouse_left_in = 1'b0; wait_cyc(20);
        bus.ypos_in = 12'd600;
        frame(3, 3); frame(3, 3);
        bus.mouse_left_in = 1'b1; wait_cyc(8);
        rst = 1'b1; wait_cyc(2);
        expect_val("mid_reset_paddle_y", int'(bus.paddle_y), YMID);
        rst = 1'b0; wait_cyc(1);
        expect_val("no_tick_after_reset", int'(bus.frame_tick), 0);
        wait_cyc(30);
        bus.mouse_left_in = 1'b0; wait_cyc(20);
        vcnt = 1; bcnt = 1;
        for (int c = 0; c < 5000; c++) begin
            if (--vcnt == 0) begin bus.vblnk_in = ~bus.vblnk_in; vcnt = $urandom_range(1, 12); end
            if (--bcnt == 0) begin bus.mouse_left_in = ~bus.mouse_left_in; bcnt = $urandom_range(1, 40); end
            if ($urandom_range(0, 3) == 0)
                bus.ypos_in = 12'($urandom_range(0, 1) ? $urandom_range(0, 4095) : $urandom_range(640, 700));
            if ($urandom_range(0, 3) == 0) bus.ypos_sec_in = 12'($urandom_range(0, 4095));
            rst = ($urandom_range(0, 599) == 0);
            wait_cyc(1);
        end
        rst = 1'b0; bus.vblnk_in = 1'b0; bus.mouse_left_in = 1'b0;
        wait_cyc(40);
        expect_val("frame_queue_drained", fq.size(), 0);
        expect_val("pulse_queue_drained", pq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
